// File: rtl/approx_mul4_err_eval_if.sv
// Operand/product bus between the error engine and the approximate multiplier.
// The engine drives the operands and the multiplier returns the product.
interface approx_mul4_err_eval_if;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] approx_r;

  modport master (
    output op_a,
    output op_b,
    input  approx_r
  );

  modport slave (
    input  op_a,
    input  op_b,
    output approx_r
  );
endinterface

// File: rtl/approx_mul4_err_eval.sv
// Exhaustive 4x4 approximate-multiplier error engine: sweeps all 256 pairs,
// aligns returned products with exact ones and accumulates error statistics.
module approx_mul4_err_eval #(
  parameter int EXT_LAT = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  approx_mul4_err_eval_if.master mul,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [8:0]             o_err_count,
  output logic [15:0]            o_sum_abs_err,
  output logic [17:0]            o_sum_sgn_err,
  output logic [7:0]             o_max_abs_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(EXT_LAT + 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_idx;
  logic [3:0]  r_dcnt;
  logic [3:0]  r_opa;
  logic [3:0]  r_opb;
  logic        r_opv;
  logic        w_go;
  logic [7:0]  w_exact;
  logic [7:0]  w_exact_d;
  logic        w_v_d;

  logic        r_s1_v;
  logic [7:0]  r_s1_apx;
  logic [7:0]  r_s1_ex;
  logic [8:0]  w_diff;
  logic [8:0]  w_neg;
  logic [7:0]  w_abs;

  logic [8:0]  r_cnt;
  logic [15:0] r_abs;
  logic [17:0] r_sgn;
  logic [7:0]  r_max;

  assign w_go = i_start &&
                (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_SWEEP;
      S_SWEEP: if (r_idx == 8'hff) w_next = S_DRAIN;
      S_DRAIN: if (r_dcnt == DRAIN_LAST) w_next = S_DONE;
      S_DONE:  if (i_start) w_next = S_SWEEP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_dcnt  <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_opv   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) r_idx <= '0;
      if (r_state == S_SWEEP) begin
        r_opa <= r_idx[7:4];
        r_opb <= r_idx[3:0];
        r_opv <= 1'b1;
        if (r_idx != 8'hff) r_idx <= r_idx + 8'd1;
      end else begin
        r_opv <= 1'b0;
      end
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt + 4'd1;
      else                    r_dcnt <= '0;
    end
  end

  assign mul.op_a = r_opa;
  assign mul.op_b = r_opb;
  assign w_exact  = {4'b0, r_opa} * {4'b0, r_opb};

  // Exact product rides alongside the external multiplier's own latency.
  generate
    if (EXT_LAT == 0) begin : g_nodly
      assign w_exact_d = w_exact;
      assign w_v_d     = r_opv;
    end else begin : g_dly
      logic [7:0]         r_dl_x [EXT_LAT];
      logic [EXT_LAT-1:0] r_dl_v;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dl_v <= '0;
          for (int i = 0; i < EXT_LAT; i++) r_dl_x[i] <= '0;
        end else begin
          r_dl_v[0] <= r_opv;
          r_dl_x[0] <= w_exact;
          for (int i = 1; i < EXT_LAT; i++) begin
            r_dl_v[i] <= r_dl_v[i-1];
            r_dl_x[i] <= r_dl_x[i-1];
          end
        end
      end
      assign w_exact_d = r_dl_x[EXT_LAT-1];
      assign w_v_d     = r_dl_v[EXT_LAT-1];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_v   <= 1'b0;
      r_s1_apx <= '0;
      r_s1_ex  <= '0;
    end else begin
      r_s1_v   <= w_v_d;
      r_s1_apx <= mul.approx_r;
      r_s1_ex  <= w_exact_d;
    end
  end

  assign w_diff = {1'b0, r_s1_apx} - {1'b0, r_s1_ex};
  assign w_neg  = -w_diff;
  assign w_abs  = w_diff[8] ? w_neg[7:0] : w_diff[7:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || w_go) begin
      r_cnt <= '0;
      r_abs <= '0;
      r_sgn <= '0;
      r_max <= '0;
    end else if (r_s1_v) begin
      if (w_diff != 9'd0) r_cnt <= r_cnt + 9'd1;
      r_abs <= r_abs + {8'b0, w_abs};
      r_sgn <= r_sgn + {{9{w_diff[8]}}, w_diff};
      if (w_abs > r_max) r_max <= w_abs;
    end
  end

  assign o_busy        = (r_state == S_SWEEP) ||
                         (r_state == S_DRAIN);
  assign o_done        = (r_state == S_DONE);
  assign o_err_count   = r_cnt;
  assign o_sum_abs_err = r_abs;
  assign o_sum_sgn_err = r_sgn;
  assign o_max_abs_err = r_max;

endmodule

// File: tb/tb_approx_mul4_err_eval.sv
// Bench for approx_mul4_err_eval: one engine at EXT_LAT=0 and one at
// EXT_LAT=2, each fed by a modelled multiplier, swept together.
module tb_approx_mul4_err_eval;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;

  always #5 clk = ~clk;

  approx_mul4_err_eval_if m0 ();
  approx_mul4_err_eval_if m2 ();

  logic        busy0, done0, busy2, done2;
  logic [8:0]  cnt0, cnt2;
  logic [15:0] abs0, abs2;
  logic [17:0] sgn0, sgn2;
  logic [7:0]  max0, max2;

  approx_mul4_err_eval #(.EXT_LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .mul(m0.master),
    .o_busy(busy0), .o_done(done0), .o_err_count(cnt0),
    .o_sum_abs_err(abs0), .o_sum_sgn_err(sgn0), .o_max_abs_err(max0)
  );

  approx_mul4_err_eval #(.EXT_LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .mul(m2.master),
    .o_busy(busy2), .o_done(done2), .o_err_count(cnt2),
    .o_sum_abs_err(abs2), .o_sum_sgn_err(sgn2), .o_max_abs_err(max2)
  );

  // Multiplier model: 0 exact, 1 tied zero, 2 exact plus one.
  function automatic logic [7:0] f(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (mode)
      1:       return 8'd0;
      2:       return p + 8'd1;
      default: return p;
    endcase
  endfunction

  logic [7:0] r_l1, r_l2;
  always_comb m0.approx_r = f(m0.op_a, m0.op_b);
  always @(posedge clk) begin
    r_l1 <= f(m2.op_a, m2.op_b);
    r_l2 <= r_l1;
  end
  assign m2.approx_r = r_l2;

  typedef struct {
    string name;
    int    mode;
    int    cnt;
    int    sabs;
    int    ssgn;
    int    mx;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input vec_t v);
    chk({tag, "_cnt0"}, int'(cnt0), v.cnt);
    chk({tag, "_abs0"}, int'(abs0), v.sabs);
    chk({tag, "_sgn0"}, int'($signed(sgn0)), v.ssgn);
    chk({tag, "_max0"}, int'(max0), v.mx);
    chk({tag, "_cnt2"}, int'(cnt2), v.cnt);
    chk({tag, "_abs2"}, int'(abs2), v.sabs);
    chk({tag, "_sgn2"}, int'($signed(sgn2)), v.ssgn);
    chk({tag, "_max2"}, int'(max2), v.mx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy0) + int'(busy2), 0);
    chk({tag, "_done"}, int'(done0) + int'(done2), 0);
    chk({tag, "_ops"}, int'({m0.op_a, m0.op_b, m2.op_a, m2.op_b}), 0);
    chk({tag, "_acc0"}, int'(cnt0) + int'(abs0) + int'(sgn0) + int'(max0), 0);
    chk({tag, "_acc2"}, int'(cnt2) + int'(abs2) + int'(sgn2) + int'(max2), 0);
  endtask

  task automatic run_sweep(input vec_t v);
    int n, d0, d2, bbad;
    mode = v.mode;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; d0 = -1; d2 = -1; bbad = 0;
    if (!busy0) bbad++;
    while ((d0 < 0 || d2 < 0) && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (busy0 != (n < 258)) bbad++;
      if (d0 < 0 && done0) d0 = n;
      if (d2 < 0 && done2) d2 = n;
    end
    chk({v.name, "_busy_window"}, bbad, 0);
    chk({v.name, "_done_edge0"}, d0, 258);
    chk({v.name, "_done_edge2"}, d2, 260);
    chk_stats(v.name, v);
    repeat (5) @(posedge clk);
    #1 chk({v.name, "_done_hold"}, int'(done0 & done2), 1);
  endtask

  vec_t tbl[4];
  vec_t zero_row;

  initial begin
    tbl[0] = '{"exact", 0, 0, 0, 0, 0};
    tbl[1] = '{"zero", 1, 225, 14400, -14400, 225};
    tbl[2] = '{"plus1", 2, 256, 256, 256, 1};
    tbl[3] = '{"zero_again", 1, 225, 14400, -14400, 225};
    zero_row = tbl[1];
    zero_row.name = "after_rst";

    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 4; i++) run_sweep(tbl[i]);

    // Restart ignored mid-sweep, then reset aborts the sweep.
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("restart_busy", int'(busy0), 1);
    repeat (49) @(posedge clk);
    #1 chk("restart_ignored_op", int'({m0.op_a, m0.op_b}), 149);
    repeat (29) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk_zero("midrst");
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk_zero("idle_hold");

    run_sweep(zero_row);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
